// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store requester and the data memory
// responder. The requester drives the request channel and the response
// acceptance; the responder drives request acceptance and the response.
interface data_mem_responder_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time, waits a fixed
// number of wait states, performs the access on a local word array and
// returns a registered response. Accesses beyond the implemented depth are
// flagged as errors and counted in a saturating counter.
module data_mem_responder #(
    parameter int DATA_W      = 19,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus,
    output logic [7:0]            err_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q,     state_d;
    logic [3:0]        wait_cnt_q,  wait_cnt_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [7:0]        err_count_q, err_count_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_rdata;
    logic              in_range;
    logic              access_now;
    logic              mem_we;

    // Decode the captured address and decide whether the array is touched this cycle
    always_comb begin
        mem_idx    = addr_q[IDX_W-1:0];
        in_range   = ({1'b0, addr_q} < DEPTH_L);
        access_now = (state_q == ST_WAIT) && (wait_cnt_q == 4'd0);
        mem_we     = access_now && we_q && in_range && !reset;
        mem_rdata  = mem[mem_idx];
    end

    // Next-state and next-output logic for the accept / wait / respond sequence
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    wait_cnt_d  = WAIT_L;
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    if (in_range) begin
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = we_q ? '0 : mem_rdata;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                end
            end

            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // Register all control state and outputs; reset drops any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Word array update; contents survive reset, and a reset cancels a pending write
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance A uses two wait states
// and sees directed plus randomized traffic; instance B has no wait states
// and drives the error counter into saturation.
module tb_data_mem_responder;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;
    localparam int PERIOD = 10;
    localparam int NWORDS = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              checkData;
        logic [7:0]        errCount;
        longint            riseAt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] errCountA, errCountB;

    data_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busA ();
    data_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busB ();

    data_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_A)) dutA (
        .clk(clk), .reset(reset), .bus(busA), .err_count(errCountA));

    data_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_B)) dutB (
        .clk(clk), .reset(reset), .bus(busB), .err_count(errCountB));

    always #(PERIOD/2) clk = ~clk;

    exp_t qA[$];
    exp_t qB[$];
    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] modelMem [NWORDS];
    bit   written [NWORDS];
    int   modelErrs = 0;
    bit   randMode = 1'b0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_req_ready", 64'(busA.req_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(busA.rsp_valid), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(busA.rsp_rdata), 64'd0);
        checkOutput("rst_rsp_err",   64'(busA.rsp_err),   64'd0);
        checkOutput("rst_err_count", 64'(errCountA),      64'd0);
    endtask

    // Issue one request to instance A and, if a response is due, predict it
    task automatic applyStimulus(input bit we, input int addr, input logic [DATA_W-1:0] wdata, input bit expectRsp);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (busA.req_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checkOutput("req_ready_timeout_A", 64'd0, 64'd1);
            return;
        end
        busA.req_valid = 1'b1;
        busA.req_we    = we;
        busA.req_addr  = ADDR_W'(addr);
        busA.req_wdata = wdata;
        @(posedge clk);
        #1;
        busA.req_valid = 1'b0;
        busA.req_we    = 1'($urandom);
        busA.req_addr  = ADDR_W'($urandom);
        busA.req_wdata = DATA_W'($urandom);
        if (expectRsp) begin
            e.riseAt = longint'($time) - 1 + (WAIT_A + 1) * PERIOD + PERIOD / 2;
            if (addr < DEPTH) begin
                e.err = 1'b0;
                if (we) begin
                    modelMem[addr] = wdata;
                    written[addr]  = 1'b1;
                    e.rdata        = '0;
                    e.checkData    = 1'b1;
                end else begin
                    e.rdata     = modelMem[addr];
                    e.checkData = written[addr];
                end
            end else begin
                e.err       = 1'b1;
                e.rdata     = '0;
                e.checkData = 1'b1;
                if (modelErrs < 255) modelErrs++;
            end
            e.errCount = 8'(modelErrs);
            qA.push_back(e);
        end
    endtask

    task automatic waitDrainA();
        int g = 0;
        while ((qA.size() != 0 || busA.req_ready !== 1'b1 || busA.rsp_valid !== 1'b0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) checkOutput("drain_timeout_A", 64'd0, 64'd1);
    endtask

    // Random response backpressure on instance A, changed just after each rising edge
    always @(posedge clk) begin
        if (randMode) begin
            #1;
            busA.rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor A: pops a prediction when a response appears and watches it stay stable
    bit   prevValidA = 1'b0;
    bit   prevHsA = 1'b0;
    exp_t eA;
    logic [DATA_W-1:0] heldDataA;
    logic heldErrA;
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prevValidA = 1'b0;
            prevHsA    = 1'b0;
        end else begin
            if (prevHsA) begin
                checkOutput("A_req_ready_after_hs", 64'(busA.req_ready), 64'd1);
                checkOutput("A_rsp_valid_after_hs", 64'(busA.rsp_valid), 64'd0);
            end
            if (busA.rsp_valid === 1'b1 && !prevValidA) begin
                heldDataA = busA.rsp_rdata;
                heldErrA  = busA.rsp_err;
                if (qA.size() == 0) begin
                    checkOutput("A_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    eA = qA.pop_front();
                    checkOutput("A_rsp_rise_time", 64'($time), 64'(eA.riseAt));
                    checkOutput("A_rsp_err", 64'(busA.rsp_err), 64'(eA.err));
                    if (eA.checkData) checkOutput("A_rsp_rdata", 64'(busA.rsp_rdata), 64'(eA.rdata));
                    checkOutput("A_err_count", 64'(errCountA), 64'(eA.errCount));
                    checkOutput("A_req_ready_busy", 64'(busA.req_ready), 64'd0);
                end
            end else if (busA.rsp_valid === 1'b1) begin
                checkOutput("A_hold_rdata", 64'(busA.rsp_rdata), 64'(heldDataA));
                checkOutput("A_hold_err",   64'(busA.rsp_err),   64'(heldErrA));
                checkOutput("A_hold_req_ready", 64'(busA.req_ready), 64'd0);
            end
            prevHsA    = (busA.rsp_valid === 1'b1) && (busA.rsp_ready === 1'b1);
            prevValidA = (busA.rsp_valid === 1'b1);
        end
    end

    // Monitor B: zero-wait instance, only out-of-range reads are sent to it
    bit   prevValidB = 1'b0;
    bit   prevHsB = 1'b0;
    exp_t eB;
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prevValidB = 1'b0;
            prevHsB    = 1'b0;
        end else begin
            if (prevHsB) checkOutput("B_req_ready_after_hs", 64'(busB.req_ready), 64'd1);
            if (busB.rsp_valid === 1'b1 && !prevValidB) begin
                if (qB.size() == 0) begin
                    checkOutput("B_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    eB = qB.pop_front();
                    checkOutput("B_rsp_rise_time", 64'($time), 64'(eB.riseAt));
                    checkOutput("B_rsp_err",   64'(busB.rsp_err),   64'(eB.err));
                    checkOutput("B_rsp_rdata", 64'(busB.rsp_rdata), 64'(eB.rdata));
                    checkOutput("B_err_count", 64'(errCountB),      64'(eB.errCount));
                end
            end
            prevHsB    = (busB.rsp_valid === 1'b1) && (busB.rsp_ready === 1'b1);
            prevValidB = (busB.rsp_valid === 1'b1);
        end
    end

    // Main sequence: reset, directed scenarios, random traffic, then saturation on B
    initial begin
        int   g;
        exp_t e;
        bit   we;
        int   addr;

        reset = 1'b1;
        busA.req_valid = 1'b0; busA.req_we = 1'b0; busA.req_addr = '0; busA.req_wdata = '0; busA.rsp_ready = 1'b1;
        busB.req_valid = 1'b0; busB.req_we = 1'b0; busB.req_addr = '0; busB.req_wdata = '0; busB.rsp_ready = 1'b1;
        for (int i = 0; i < NWORDS; i++) begin
            written[i]  = 1'b0;
            modelMem[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkResetState();

        $display("[TB] write/read with latency");
        applyStimulus(1'b1, 'h10, 19'h5A5A5, 1'b1);
        applyStimulus(1'b0, 'h10, '0, 1'b1);
        waitDrainA();

        $display("[TB] backpressure");
        busA.rsp_ready = 1'b0;
        applyStimulus(1'b0, 'h10, '0, 1'b1);
        g = 0;
        while (busA.rsp_valid !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) checkOutput("bp_rsp_timeout", 64'd0, 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        busA.rsp_ready = 1'b1;
        waitDrainA();

        $display("[TB] out-of-range");
        applyStimulus(1'b1, 199, 19'h1ABCD, 1'b1);
        applyStimulus(1'b1, 200, 19'h7FFFF, 1'b1);
        applyStimulus(1'b0, 255, '0, 1'b1);
        applyStimulus(1'b0, 199, '0, 1'b1);
        waitDrainA();
        checkOutput("oor_err_count", 64'(errCountA), 64'd2);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 'h20, 19'h00011, 1'b1);
        waitDrainA();
        applyStimulus(1'b1, 'h20, 19'h12345, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelErrs = 0;
        checkResetState();
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 'h20, '0, 1'b1);
        waitDrainA();

        $display("[TB] random traffic");
        randMode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) addr = $urandom_range(DEPTH, NWORDS - 1);
            else                           addr = $urandom_range(0, 31);
            applyStimulus(we, addr, DATA_W'($urandom), 1'b1);
        end
        randMode = 1'b0;
        @(posedge clk);
        #2;
        busA.rsp_ready = 1'b1;
        waitDrainA();

        $display("[TB] zero wait and saturation");
        for (int i = 0; i < 260; i++) begin
            g = 0;
            @(negedge clk);
            while (busB.req_ready !== 1'b1 && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) begin
                checkOutput("req_ready_timeout_B", 64'd0, 64'd1);
                break;
            end
            busB.req_valid = 1'b1;
            busB.req_we    = 1'b0;
            busB.req_addr  = ADDR_W'($urandom_range(DEPTH, NWORDS - 1));
            @(posedge clk);
            #1;
            busB.req_valid = 1'b0;
            e.riseAt    = longint'($time) - 1 + (WAIT_B + 1) * PERIOD + PERIOD / 2;
            e.err       = 1'b1;
            e.rdata     = '0;
            e.checkData = 1'b1;
            e.errCount  = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            qB.push_back(e);
        end
        g = 0;
        while ((qB.size() != 0 || busB.rsp_valid !== 1'b0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) checkOutput("drain_timeout_B", 64'd0, 64'd1);
        checkOutput("B_err_count_saturated", 64'(errCountB), 64'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs the read or write on an internal word array, and returns a response over a second valid/ready handshake. It sits between `top`'s processor datapath and on-chip data storage. It gives the core a memory with non-zero, parameterised latency so core stall logic is exercised. It also counts accesses to unmapped addresses.

## Interface
- `DATA_W`, 19: data word width in bits.
- `ADDR_W`, 8: request address width in bits.
- `DEPTH`, 200: number of implemented words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- `WAIT_CYCLES`, 2: extra wait states per access; range 0..15.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester accepts the response.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors.
- `rsp_err`  out  1  1 = address ≥ DEPTH.
- `err_count`  out  8  saturating count of errored requests.

## Operation
- States:
  - IDLE: `req_ready`=1.
    - On `req_valid && req_ready`, capture `req_we`, `req_addr` and `req_wdata`.
    - Load `wait_cnt` = WAIT_CYCLES and go to WAIT.
  - WAIT:
    - If `wait_cnt` ≠ 0, decrement it and stay in WAIT.
    - If `wait_cnt` = 0, perform the access and go to RESP.
  - RESP: `rsp_valid`=1 and outputs are held stable. On `rsp_valid && rsp_ready`, go to IDLE.
- Access rules, applied in the WAIT→RESP edge:
  - Address < DEPTH, read: `rsp_rdata` = mem[addr], `rsp_err`=0.
  - Address < DEPTH, write: mem[addr] ← wdata, `rsp_rdata`=0, `rsp_err`=0.
  - Address ≥ DEPTH, read or write: no array update, `rsp_rdata`=0, `rsp_err`=1, and `err_count` increments, saturating at 255.
- Request inputs are sampled only at the accept edge. Changes on them outside IDLE are ignored.
- `req_ready` is 0 in WAIT and RESP. Only one transaction is in flight at a time.
- Reset, including mid-transaction:
  - State → IDLE; the in-flight transaction is dropped with no response.
  - A write whose array update has not yet happened is discarded.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `err_count`=0.
  - Array contents are not cleared; reads of never-written words are undefined.

## Timing
- Request accepted at edge k: `rsp_valid` rises after edge k+WAIT_CYCLES+1. With WAIT_CYCLES=0, the response follows one cycle after acceptance.
- If `rsp_ready`=1 while `rsp_valid`=1, the handshake completes at the next edge k+WAIT_CYCLES+2. `req_ready` is 1 in the following cycle.
- Best-case throughput: one transaction per WAIT_CYCLES+3 cycles.
- `rsp_valid` may wait indefinitely for `rsp_ready`. `rsp_rdata` and `rsp_err` must not change while waiting.
- A read immediately after a write to the same address returns the new data, since the write completed before the prior response.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset check:
  - Stimulus: hold `reset`=1 for 2 cycles, then release.
  - Required: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `err_count`=0.
- Write/read with latency, WAIT_CYCLES=2:
  - Stimulus: write 0x5A5A5 to addr 0x10, then read addr 0x10.
  - Required: each `rsp_valid` rises exactly 3 cycles after acceptance. The read returns 0x5A5A5 with `rsp_err`=0.
- Backpressure:
  - Stimulus: read addr 0x10 with `rsp_ready`=0 for 5 cycles, then 1.
  - Required: `rsp_valid` and `rsp_rdata`=0x5A5A5 stay stable for all 5 cycles. `req_ready`=0 throughout, then returns to 1 one cycle after the handshake.
- Out-of-range:
  - Stimulus: with DEPTH=200, write 0x7FFFF to addr 200, then read addr 255.
  - Required: both responses have `rsp_err`=1 and `rsp_rdata`=0, and `err_count`=2. A following read of addr 199 returns the previously written value with `rsp_err`=0.
- Reset mid-operation:
  - Stimulus: after addr 0x20 holds 0x00011, issue a write of 0x12345 to addr 0x20, then assert `reset` during WAIT.
  - Required: no response is produced. A read of 0x20 after reset returns 0x00011.
- Zero wait and saturation:
  - Stimulus: with WAIT_CYCLES=0, issue 260 back-to-back out-of-range reads.
  - Required: each response arrives 1 cycle after acceptance, and `err_count` stops at 255.
